// File: rtl/ntt_bfu_ctrl_pkg.sv
// Shared types and defaults for the NTT butterfly-unit sequencer.
// Optional build macro: CTRL_CYCLE_CNT_EN (adds a busy-cycle counter port on ntt_bfu_ctrl).
package ntt_bfu_ctrl_pkg;

    // Coefficient / twiddle word width (covers moduli up to 4095, e.g. 3329).
    localparam int DATA_W      = 12;

    // Default transform size exponent and BFU pipeline depth.
    localparam int LOGN_DEF    = 3;
    localparam int BFU_LAT_DEF = 8;

    // Transform direction as carried on bfu_op and tw_addr[LOGN].
    localparam logic OP_NTT  = 1'b0;
    localparam logic OP_INTT = 1'b1;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Width of the stage counter for a given LOGN (at least one bit).
    function automatic int stage_w(input int logn);
        return (logn > 1) ? $clog2(logn) : 1;
    endfunction

endpackage

// File: rtl/ntt_bfu_ctrl_addr_gen.sv
// Combinational butterfly address generator.
// Maps (stage, butterfly index, direction) to the coefficient pair (a, b) and the
// twiddle ROM address. CT (op=0) halves the pair distance every stage; GS (op=1)
// doubles it. Twiddle index is 2^s+g for CT and N/2^(s+1)+g for GS, with the
// direction bit selecting the inverse table in the upper half of the ROM.
module ntt_bfu_ctrl_addr_gen
    import ntt_bfu_ctrl_pkg::*;
#(
    parameter int LOGN = LOGN_DEF,
    parameter int S_W  = stage_w(LOGN)
) (
    input  logic [S_W-1:0]  stage,
    input  logic [LOGN-2:0] idx,
    input  logic            op,
    output logic [LOGN-1:0] addr_a,
    output logic [LOGN-1:0] addr_b,
    output logic [LOGN:0]   tw_addr
);

    logic [LOGN-1:0] sh_ct;
    logic [LOGN-1:0] sh_gs;
    logic [LOGN-1:0] sh_pair;
    logic [LOGN-1:0] sh_tw;
    logic [LOGN-1:0] half;
    logic [LOGN-1:0] k_ext;
    logic [LOGN-1:0] grp;
    logic [LOGN-1:0] ofs;
    logic [LOGN-1:0] tw_idx;

    // Split the index into group and offset, then place the pair and pick the twiddle.
    always_comb begin
        sh_ct   = LOGN'(LOGN - 1) - LOGN'(stage);
        sh_gs   = LOGN'(stage);
        // log2 of the pair distance; the twiddle base uses the other direction's exponent.
        sh_pair = op ? sh_gs : sh_ct;
        sh_tw   = op ? sh_ct : sh_gs;
        half    = LOGN'(1) << sh_pair;
        k_ext   = {1'b0, idx};
        grp     = k_ext >> sh_pair;
        ofs     = k_ext & (half - LOGN'(1));
        // b never exceeds N-1 because a always has the 'half' bit clear.
        addr_a  = (grp << (sh_pair + LOGN'(1))) | ofs;
        addr_b  = addr_a + half;
        tw_idx  = (LOGN'(1) << sh_tw) + grp;
        tw_addr = {op, tw_idx};
    end

endmodule

// File: rtl/ntt_bfu_ctrl.sv
// NTT/INTT butterfly sequencer.
// Reads coefficient pairs and twiddles, feeds the BFU, and writes the BFU results
// back in place after the fixed pipeline latency. One full transform per start.
// Stage flow: RUN issues N/2 butterflies back to back, DRAIN waits for the last
// write of the stage so the next stage never reads stale data.
// Optional build macro: CTRL_CYCLE_CNT_EN adds cycle_cnt[31:0], counting busy cycles.
module ntt_bfu_ctrl
    import ntt_bfu_ctrl_pkg::*;
#(
    parameter int LOGN    = LOGN_DEF,
    parameter int BFU_LAT = BFU_LAT_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              op,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [LOGN-1:0]   rd_addr1,
    output logic [LOGN-1:0]   rd_addr2,
    input  logic [DATA_W-1:0] rd_data1,
    input  logic [DATA_W-1:0] rd_data2,
    output logic [LOGN:0]     tw_addr,
    input  logic [DATA_W-1:0] tw_data,
    output logic [DATA_W-1:0] bfu_in1,
    output logic [DATA_W-1:0] bfu_in2,
    output logic [DATA_W-1:0] bfu_gamma,
    output logic              bfu_op,
    input  logic [DATA_W-1:0] bfu_out1,
    input  logic [DATA_W-1:0] bfu_out2,
    output logic              wr_en,
    output logic [LOGN-1:0]   wr_addr1,
    output logic [LOGN-1:0]   wr_addr2,
    output logic [DATA_W-1:0] wr_data1,
    output logic [DATA_W-1:0] wr_data2
`ifdef CTRL_CYCLE_CNT_EN
    ,
    output logic [31:0]       cycle_cnt
`endif
);

    localparam int S_W = stage_w(LOGN);
    localparam int K_W = LOGN - 1;
    // One cycle of read latency plus the BFU pipeline.
    localparam int DL  = BFU_LAT + 1;

    localparam logic [S_W-1:0] S_LAST = S_W'(LOGN - 1);
    localparam logic [K_W-1:0] K_LAST = '1;

    state_e          state_q,    state_d;
    logic [S_W-1:0]  stage_q,    stage_d;
    logic [K_W-1:0]  idx_q,      idx_d;
    logic            op_q,       op_d;
    logic            busy_q,     busy_d;
    logic            done_q,     done_d;
    logic            rd_en_q,    rd_en_d;
    logic [LOGN-1:0] rd_addr1_q, rd_addr1_d;
    logic [LOGN-1:0] rd_addr2_q, rd_addr2_d;
    logic [LOGN:0]   tw_addr_q,  tw_addr_d;

    // Write-back delay line: valid bits plus the a/b addresses of each butterfly.
    logic [DL-1:0]   vld_q, vld_d;
    logic [LOGN-1:0] dla_q [DL];
    logic [LOGN-1:0] dla_d [DL];
    logic [LOGN-1:0] dlb_q [DL];
    logic [LOGN-1:0] dlb_d [DL];

    logic [LOGN-1:0] gen_a;
    logic [LOGN-1:0] gen_b;
    logic [LOGN:0]   gen_tw;
    logic            pipe_busy;

    // Addresses are generated for the next (stage, index) so they register with rd_en.
    ntt_bfu_ctrl_addr_gen #(
        .LOGN (LOGN),
        .S_W  (S_W)
    ) u_addr_gen (
        .stage   (stage_d),
        .idx     (idx_d),
        .op      (op_d),
        .addr_a  (gen_a),
        .addr_b  (gen_b),
        .tw_addr (gen_tw)
    );

    // A butterfly is still in flight unless only the final write-back slot is occupied;
    // that lets the next stage read the cycle right after the last write.
    assign pipe_busy = rd_en_q | (|vld_q[DL-2:0]);

    // Sequencer next state: FSM transitions and stage / butterfly counters.
    always_comb begin
        // NOTE: every variable gets its default first, so no path can leave it unassigned and infer a latch.
        state_d = state_q;
        stage_d = stage_q;
        idx_d   = idx_q;
        op_d    = op_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    stage_d = '0;
                    idx_d   = '0;
                    op_d    = op;
                end
            end
            ST_RUN: begin
                if (idx_q == K_LAST) begin
                    state_d = ST_DRAIN;
                end else begin
                    idx_d = idx_q + K_W'(1);
                end
            end
            ST_DRAIN: begin
                if (!pipe_busy) begin
                    idx_d = '0;
                    if (stage_q == S_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                        stage_d = stage_q + S_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered strobes and read/twiddle addresses, aligned with the next state.
    always_comb begin
        rd_en_d    = (state_d == ST_RUN);
        busy_d     = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d     = (state_d == ST_DONE);
        rd_addr1_d = rd_addr1_q;
        rd_addr2_d = rd_addr2_q;
        tw_addr_d  = tw_addr_q;
        if (rd_en_d) begin
            rd_addr1_d = gen_a;
            rd_addr2_d = gen_b;
            tw_addr_d  = gen_tw;
        end
    end

    // Shift each issued butterfly's valid and addresses toward the write-back port.
    always_comb begin
        vld_d    = {vld_q[DL-2:0], rd_en_q};
        dla_d[0] = rd_addr1_q;
        dlb_d[0] = rd_addr2_q;
        for (int i = 1; i < DL; i++) begin
            dla_d[i] = dla_q[i-1];
            dlb_d[i] = dlb_q[i-1];
        end
    end

    // State, counters, registered outputs and the write-back delay line.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            stage_q    <= '0;
            idx_q      <= '0;
            op_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_addr1_q <= '0;
            rd_addr2_q <= '0;
            tw_addr_q  <= '0;
            vld_q      <= '0;
            // NOTE: the address delay line is reset as well so wr_addr reads 0 out of reset; a storage RAM would not be.
            for (int i = 0; i < DL; i++) begin
                dla_q[i] <= '0;
                dlb_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            state_q    <= state_d;
            stage_q    <= stage_d;
            idx_q      <= idx_d;
            op_q       <= op_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_en_q    <= rd_en_d;
            rd_addr1_q <= rd_addr1_d;
            rd_addr2_q <= rd_addr2_d;
            tw_addr_q  <= tw_addr_d;
            vld_q      <= vld_d;
            for (int i = 0; i < DL; i++) begin
                dla_q[i] <= dla_d[i];
                dlb_q[i] <= dlb_d[i];
            end
        end
    end

`ifdef CTRL_CYCLE_CNT_EN
    logic [31:0] cyc_cnt_q, cyc_cnt_d;

    // Busy-cycle counter: cleared on an accepted start, saturating, held after done.
    always_comb begin
        cyc_cnt_d = cyc_cnt_q;
        if ((state_q == ST_IDLE) && start) begin
            cyc_cnt_d = '0;
        end else if (busy_q && (cyc_cnt_q != '1)) begin
            cyc_cnt_d = cyc_cnt_q + 32'd1;
        end
    end

    // Busy-cycle counter register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cyc_cnt_q <= '0;
        end else begin
            cyc_cnt_q <= cyc_cnt_d;
        end
    end

    assign cycle_cnt = cyc_cnt_q;
`endif

    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_en     = rd_en_q;
    assign rd_addr1  = rd_addr1_q;
    assign rd_addr2  = rd_addr2_q;
    assign tw_addr   = tw_addr_q;
    assign bfu_op    = op_q;

    // Memory read data and twiddle go straight into the BFU.
    assign bfu_in1   = rd_data1;
    assign bfu_in2   = rd_data2;
    assign bfu_gamma = tw_data;

    // BFU results go straight back out; out1 always lands at a, out2 at b.
    assign wr_en     = vld_q[DL-1];
    assign wr_addr1  = dla_q[DL-1];
    assign wr_addr2  = dlb_q[DL-1];
    assign wr_data1  = bfu_out1;
    assign wr_data2  = bfu_out2;

endmodule

// File: tb/tb_ntt_bfu_ctrl.sv
// Bench for ntt_bfu_ctrl: coefficient RAM and twiddle ROM models, an 8-cycle BFU
// stub (echo, or modular CT/GS butterfly with p=3329), and a scoreboard that queues
// expected write-backs at each read and compares them when wr_en fires.
`timescale 1ns/1ps
module tb_ntt_bfu_ctrl;
    import ntt_bfu_ctrl_pkg::*;

    localparam int LOGN = 3;
    localparam int N    = 1 << LOGN;
    localparam int NB   = (N / 2) * LOGN;
    localparam int LAT  = 8;
    localparam int P    = 3329;

    logic              clk;
    logic              rstn;
    logic              start;
    logic              op;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [LOGN-1:0]   rd_addr1, rd_addr2;
    logic [DATA_W-1:0] rd_data1, rd_data2;
    logic [LOGN:0]     tw_addr;
    logic [DATA_W-1:0] tw_data;
    logic [DATA_W-1:0] bfu_in1, bfu_in2, bfu_gamma;
    logic              bfu_op;
    logic [DATA_W-1:0] bfu_out1, bfu_out2;
    logic              wr_en;
    logic [LOGN-1:0]   wr_addr1, wr_addr2;
    logic [DATA_W-1:0] wr_data1, wr_data2;
`ifdef CTRL_CYCLE_CNT_EN
    logic [31:0]       cycle_cnt;
`endif

    ntt_bfu_ctrl #(.LOGN(LOGN), .BFU_LAT(LAT)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .op        (op),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .rd_data1  (rd_data1),
        .rd_data2  (rd_data2),
        .tw_addr   (tw_addr),
        .tw_data   (tw_data),
        .bfu_in1   (bfu_in1),
        .bfu_in2   (bfu_in2),
        .bfu_gamma (bfu_gamma),
        .bfu_op    (bfu_op),
        .bfu_out1  (bfu_out1),
        .bfu_out2  (bfu_out2),
        .wr_en     (wr_en),
        .wr_addr1  (wr_addr1),
        .wr_addr2  (wr_addr2),
        .wr_data1  (wr_data1),
        .wr_data2  (wr_data2)
`ifdef CTRL_CYCLE_CNT_EN
        ,
        .cycle_cnt (cycle_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference butterfly: returns {out1, out2}.
    function automatic logic [2*DATA_W-1:0] bfu_ref(input logic o, input logic [DATA_W-1:0] x,
                                                    input logic [DATA_W-1:0] y, input logic [DATA_W-1:0] w);
        int t, o1, o2;
        if (!o) begin
            t  = (int'(w) * int'(y)) % P;
            o1 = (int'(x) + t) % P;
            o2 = (int'(x) + P - t) % P;
        end else begin
            o1 = (int'(x) + int'(y)) % P;
            o2 = (((int'(x) + P - int'(y)) % P) * int'(w)) % P;
        end
        return {DATA_W'(o1), DATA_W'(o2)};
    endfunction

    // ---------------- memory / BFU models ----------------
    logic [DATA_W-1:0] mem [N];
    logic [DATA_W-1:0] rom [2*N];
    logic [DATA_W-1:0] gm  [N];
    logic              arith = 1'b0;

    always @(posedge clk) begin
        if (rd_en) begin
            rd_data1 <= mem[rd_addr1];
            rd_data2 <= mem[rd_addr2];
        end
        tw_data <= rom[tw_addr];
        if (wr_en) begin
            mem[wr_addr1] <= wr_data1;
            mem[wr_addr2] <= wr_data2;
        end
    end

    logic [DATA_W-1:0] pipe1 [LAT];
    logic [DATA_W-1:0] pipe2 [LAT];
    logic [2*DATA_W-1:0] stub_r;
    always @(posedge clk) begin
        stub_r = arith ? bfu_ref(bfu_op, bfu_in1, bfu_in2, bfu_gamma) : {bfu_in1, bfu_in2};
        pipe1[0] <= stub_r[2*DATA_W-1:DATA_W];
        pipe2[0] <= stub_r[DATA_W-1:0];
        for (int i = 1; i < LAT; i++) begin
            pipe1[i] <= pipe1[i-1];
            pipe2[i] <= pipe2[i-1];
        end
    end
    assign bfu_out1 = pipe1[LAT-1];
    assign bfu_out2 = pipe2[LAT-1];

    // ---------------- expected issue order (loop formulation) ----------------
    logic [LOGN-1:0] ea  [NB];
    logic [LOGN-1:0] eb  [NB];
    logic [LOGN:0]   etw [NB];

    task automatic build_exp(input logic o);
        int n = 0;
        int kk = 1;
        if (!o) begin
            for (int len = N / 2; len >= 1; len = len / 2) begin
                for (int st = 0; st < N; st += 2 * len) begin
                    for (int j = st; j < st + len; j++) begin
                        ea[n] = LOGN'(j); eb[n] = LOGN'(j + len); etw[n] = {1'b0, LOGN'(kk)}; n++;
                    end
                    kk++;
                end
            end
        end else begin
            for (int len = 1; len <= N / 2; len = len * 2) begin
                for (int st = 0; st < N; st += 2 * len) begin
                    kk = N / (2 * len) + st / (2 * len);
                    for (int j = st; j < st + len; j++) begin
                        ea[n] = LOGN'(j); eb[n] = LOGN'(j + len); etw[n] = {1'b1, LOGN'(kk)}; n++;
                    end
                end
            end
        end
    endtask

    // Golden in-place transform over gm, applied butterfly by butterfly in issue order.
    task automatic golden(input logic o);
        logic [2*DATA_W-1:0] r;
        for (int n = 0; n < NB; n++) begin
            r = bfu_ref(o, gm[ea[n]], gm[eb[n]], rom[etw[n]]);
            gm[ea[n]] = r[2*DATA_W-1:DATA_W];
            gm[eb[n]] = r[DATA_W-1:0];
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    typedef struct packed {
        logic [LOGN-1:0]   a;
        logic [LOGN-1:0]   b;
        logic [DATA_W-1:0] d1;
        logic [DATA_W-1:0] d2;
    } sb_t;
    sb_t sbq [$];

    logic              run_op = 1'b0;
    logic              gam_vld = 1'b0;
    logic [DATA_W-1:0] gam_exp;
    int c0 = 0, rel = 0;
    int iss_idx = 0, n_wr = 0, n_done = 0;
    int first_rd = -1, st1_rd = -1, first_wr = -1, last_wr = -1, done_rel = -1;
    int first_busy = -1, last_busy = -1;

    always @(negedge clk) begin
        sb_t e;
        logic [2*DATA_W-1:0] r;
        if (rstn) begin
            rel = cyc - c0;
            if (gam_vld) check("gamma", bfu_gamma, gam_exp);
            gam_vld = 1'b0;
            if (rd_en) begin
                if (iss_idx < NB) begin
                    check($sformatf("rd_a[%0d]", iss_idx), rd_addr1, ea[iss_idx]);
                    check($sformatf("rd_b[%0d]", iss_idx), rd_addr2, eb[iss_idx]);
                    check($sformatf("tw[%0d]", iss_idx), tw_addr, etw[iss_idx]);
                    r = arith ? bfu_ref(run_op, mem[ea[iss_idx]], mem[eb[iss_idx]], rom[etw[iss_idx]])
                              : {mem[ea[iss_idx]], mem[eb[iss_idx]]};
                    e.a = ea[iss_idx]; e.b = eb[iss_idx];
                    e.d1 = r[2*DATA_W-1:DATA_W]; e.d2 = r[DATA_W-1:0];
                    sbq.push_back(e);
                    gam_exp = rom[etw[iss_idx]];
                    gam_vld = 1'b1;
                end else begin
                    check("rd_extra", 1, 0);
                end
                if (iss_idx == 0) first_rd = rel;
                if (iss_idx == N / 2) st1_rd = rel;
                iss_idx++;
            end
            if (wr_en) begin
                if (sbq.size() == 0) begin
                    check("wr_unexpected", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    check("wr_a", wr_addr1, e.a);
                    check("wr_b", wr_addr2, e.b);
                    check("wr_d1", wr_data1, e.d1);
                    check("wr_d2", wr_data2, e.d2);
                end
                if (first_wr < 0) first_wr = rel;
                last_wr = rel;
                n_wr++;
            end
            if (busy) begin
                if (first_busy < 0) first_busy = rel;
                last_busy = rel;
            end
            if (done) begin
                n_done++;
                done_rel = rel;
                check("done_busy_low", busy, 0);
            end
        end
    end

    // ---------------- run one transform ----------------
    task automatic run(input logic o, input int abort_at, input int ign_at);
        bit aborted = 0;
        build_exp(o);
        run_op = o;
        iss_idx = 0; n_wr = 0; n_done = 0;
        first_rd = -1; st1_rd = -1; first_wr = -1; last_wr = -1; done_rel = -1;
        first_busy = -1; last_busy = -1;
        sbq.delete();
        gam_vld = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; op = o; c0 = cyc;
        for (int i = 0; i < 200 && n_done == 0; i++) begin
            @(posedge clk); #1;
            start = ((cyc - c0) == ign_at);
            op    = ((cyc - c0) == ign_at) ? ~o : o;
            if ((cyc - c0) == abort_at) begin
                check("abort_busy_before", busy, 1);
                rstn = 1'b0;
                #1;
                check("abort_busy", busy, 0);
                check("abort_wr_en", wr_en, 0);
                check("abort_rd_en", rd_en, 0);
                sbq.delete();
                gam_vld = 1'b0;
                start = 1'b0;
                repeat (2) @(posedge clk);
                @(negedge clk) rstn = 1'b1;
                repeat (15) @(negedge clk);
                check("abort_flushed_wr", n_wr < NB, 1);
                aborted = 1;
                break;
            end
        end
        start = 1'b0;
        op = o;
        if (!aborted) begin
            if (n_done == 0) check("timeout_done", 0, 1);
            repeat (3) @(negedge clk);
            check("done_pulses", n_done, 1);
            check("issued", iss_idx, NB);
            check("written", n_wr, NB);
            check("sb_empty", sbq.size(), 0);
            check("bfu_op", bfu_op, o);
            check("first_rd_cyc", first_rd, 1);
            check("first_wr_cyc", first_wr, 10);
            check("stage1_rd_cyc", st1_rd, 14);
            check("last_wr_cyc", last_wr, 39);
            check("done_cyc", done_rel, 40);
            check("busy_first", first_busy, 1);
            check("busy_last", last_busy, 39);
`ifdef CTRL_CYCLE_CNT_EN
            check("cycle_cnt", cycle_cnt, 39);
`endif
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rstn = 1'b0; start = 1'b0; op = 1'b0;
        for (int i = 0; i < N; i++) mem[i] = DATA_W'(16 * i + 3);
        for (int i = 0; i < 2 * N; i++) rom[i] = DATA_W'($urandom_range(1, P - 1));

        repeat (3) @(posedge clk); #1;
        check("rst_outputs", {busy, done, rd_en, wr_en, bfu_op, rd_addr1, rd_addr2,
                              tw_addr, wr_addr1, wr_addr2}, '0);
        @(negedge clk) rstn = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_no_rd", iss_idx, 0);
        check("idle_busy", busy, 0);

        // Echo BFU: NTT with a stray start/op flip at cycle 5, then INTT.
        run(OP_NTT, -1, 5);
        run(OP_INTT, -1, -1);

        // Reset at cycle 20 aborts; a fresh start afterwards runs normally.
        run(OP_NTT, 20, -1);
        run(OP_NTT, -1, -1);

        // Modular butterflies: random input, NTT then INTT against the golden model.
        arith = 1'b1;
        for (int i = 0; i < N; i++) begin
            mem[i] = DATA_W'($urandom_range(0, P - 1));
            gm[i]  = mem[i];
        end
        build_exp(OP_NTT);
        golden(OP_NTT);
        run(OP_NTT, -1, -1);
        for (int i = 0; i < N; i++) check($sformatf("ntt_mem[%0d]", i), mem[i], gm[i]);
        build_exp(OP_INTT);
        golden(OP_INTT);
        run(OP_INTT, -1, -1);
        for (int i = 0; i < N; i++) check($sformatf("intt_mem[%0d]", i), mem[i], gm[i]);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
